vanilla_long_op_sequencer: RTL and testbench
============================================

// Module: vanilla_long_op_sequencer
// PURPOSE
//  Shares one iterative divide unit between the int pipe (DIV/DIVU/REM/REMU) and FP pipe (FDIV.S/FSQRT.S).
//  Arbitrates, issues, collects result, returns it to the requesting pipe's writeback.
//  Tracks the single in-flight destination; flags RAW/WAW hazards to ID. One op in flight max.
// PARAMETERS
//  data_width_p      32  result width
//  reg_addr_width_p  5   register index width (int and fp files)
// PORTS
//  clk_i          in   1    clock
//  reset_n_i      in   1    async active-low reset
//  int_v_i        in   1    int pipe request valid
//  int_op_i       in   2    idiv_op_e {eDIV,eDIVU,eREM,eREMU}
//  int_rd_i       in   5    int destination
//  int_ready_o    out  1    int request accepted this cycle when int_v_i&int_ready_o
//  fp_v_i         in   1    FP pipe request valid
//  fp_sqrt_i      in   1    1=FSQRT.S, 0=FDIV.S
//  fp_rd_i        in   5    fp destination
//  fp_ready_o     out  1    FP request accepted when fp_v_i&fp_ready_o
//  flush_i        in   1    pipeline flush; squashes in-flight op
//  unit_v_o       out  1    issue valid to divide unit
//  unit_fp_o      out  1    1=fp op, 0=int op
//  unit_op_o      out  2    int: idiv_op_e; fp: {0,fp_sqrt}
//  unit_ready_i   in   1    unit accepts issue
//  unit_v_i       in   1    unit result valid
//  unit_data_i    in   32   unit result
//  unit_yumi_o    out  1    result consumed
//  int_wb_v_o / fp_wb_v_o      out 1   writeback valid to int / fp file
//  wb_rd_o        out  5    writeback destination
//  wb_data_o      out  32   writeback data
//  int_wb_yumi_i / fp_wb_yumi_i in 1   writeback taken
//  id_rs1_i, id_rs2_i, id_rd_i  in 5  ID-stage operands
//  id_fp_i        in   1    ID operands index fp file
//  hazard_o       out  1    ID must stall
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=FP (int wins first tie), tag/data/squash cleared; all outputs 0.
//  FSM IDLE->ISSUE->WAIT->WB->IDLE.
//  IDLE: ready_o asserted only to winner (comb). Sole requester wins; both -> round-robin vs last_grant.
//   Accept: latch {fp,op,rd}, update last_grant, ->ISSUE next cycle. flush_i in IDLE blocks accept.
//  ISSUE: unit_v_o=1, held stable until unit_ready_i -> WAIT. flush_i with no handshake -> IDLE, no issue.
//   flush_i same cycle as handshake: op issued, squash=1, ->WAIT.
//  WAIT: unit_yumi_o=unit_v_i (same cycle). Capture data -> WB; if squash, ->IDLE and drop. flush_i sets squash.
//  WB: int_wb_v_o=!fp, fp_wb_v_o=fp; rd/data stable until matching yumi -> IDLE.
//   flush_i in WB ignored: result architecturally owed. Min latency req->wb_v = 3 cycles + unit latency.
//  Back-to-back: new request accepted only in IDLE (1 bubble after yumi).
//  hazard_o = pending & !squash & (id_fp_i==tag.fp) & (rs1|rs2|rd == tag.rd); pending = ISSUE|WAIT|WB.
//   Int file: tag.rd==0 never hazards. Comb, same cycle.
//  Unexpected unit_v_i outside WAIT: ignore, unit_yumi_o=0; assertion fires.
//  Reset mid-op: immediate return to IDLE, result discarded; unit reset by same reset_n_i.
// STRUCTURE
//  bsg_vanilla_pkg: long_op_state_e {IDLE,ISSUE,WAIT,WB};
//   long_op_tag_s {fp,op[1:0],rd}; reuse idiv_op_e.
//  Single module; 2-way round-robin arbiter inline (flop + two gates), no sub-module.
// TESTING
//  int_v_i=1 eDIV rd=5, unit_ready_i=1, unit_v_i 10 cyc later data=7 -> int_wb_v_o, rd=5, data=7; fp_wb_v_o=0.
//  int&fp both valid from reset -> int granted; next IDLE both valid -> fp granted; alternates.
//  FDIV rd=3 in WAIT; id_fp_i=1, id_rs2_i=3 -> hazard_o=1; id_fp_i=0 -> 0; int rd=0 op -> hazard_o=0.
//  flush_i in ISSUE, unit_ready_i=0 -> IDLE next cycle, unit_v_o=0, no wb.
//  flush_i in WAIT, unit_v_i later -> unit_yumi_o=1, wb_v never asserts, hazard_o=0 after flush.
//  WB with int_wb_yumi_i=0 for 4 cycles -> wb_v/rd/data stable, ready_o=0; reset_n_i low mid-WAIT -> all outputs 0.

Source files
------------

// File: rtl/bsg_vanilla_pkg.sv
// Shared types for the vanilla core's long-latency (divide/sqrt) sequencer.
package bsg_vanilla_pkg;

    typedef enum logic [1:0] {eDIV, eDIVU, eREM, eREMU} idiv_op_e;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} long_op_state_e;

    localparam int long_op_rd_width_gp = 5;

    // Identity of the single in-flight long op; op is idiv_op_e for int, {0,sqrt} for fp.
    typedef struct packed {
        logic                           fp;
        logic [1:0]                     op;
        logic [long_op_rd_width_gp-1:0] rd;
    } long_op_tag_s;

endpackage

// File: rtl/vanilla_long_op_sequencer.sv
// Arbitrates the int and FP pipes onto one iterative divide unit, tracks the
// single in-flight destination for ID hazard detection and returns the result.
module vanilla_long_op_sequencer
    import bsg_vanilla_pkg::*;
#(
    parameter int data_width_p     = 32,
    parameter int reg_addr_width_p = long_op_rd_width_gp
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic                        int_v_i,
    input  idiv_op_e                    int_op_i,
    input  logic [reg_addr_width_p-1:0] int_rd_i,
    output logic                        int_ready_o,

    input  logic                        fp_v_i,
    input  logic                        fp_sqrt_i,
    input  logic [reg_addr_width_p-1:0] fp_rd_i,
    output logic                        fp_ready_o,

    input  logic                        flush_i,

    output logic                        unit_v_o,
    output logic                        unit_fp_o,
    output logic [1:0]                  unit_op_o,
    input  logic                        unit_ready_i,
    input  logic                        unit_v_i,
    input  logic [data_width_p-1:0]     unit_data_i,
    output logic                        unit_yumi_o,

    output logic                        int_wb_v_o,
    output logic                        fp_wb_v_o,
    output logic [reg_addr_width_p-1:0] wb_rd_o,
    output logic [data_width_p-1:0]     wb_data_o,
    input  logic                        int_wb_yumi_i,
    input  logic                        fp_wb_yumi_i,

    input  logic [reg_addr_width_p-1:0] id_rs1_i,
    input  logic [reg_addr_width_p-1:0] id_rs2_i,
    input  logic [reg_addr_width_p-1:0] id_rd_i,
    input  logic                        id_fp_i,
    output logic                        hazard_o
);

    long_op_state_e          state_r, state_n;
    long_op_tag_s            tag_r, tag_n;
    logic [data_width_p-1:0] data_r;
    logic                    squash_r, squash_n;
    logic                    last_fp_r;
    logic                    accept;
    logic                    capture;

    // Round-robin: on a tie the pipe that was not granted last time wins.
    logic grant_fp, grant_int;
    assign grant_fp  = fp_v_i & (~int_v_i | ~last_fp_r);
    assign grant_int = int_v_i & ~grant_fp;

    // NOTE: every signal written below gets a default first so no path can infer a latch.
    always_comb begin
        state_n     = state_r;
        tag_n       = tag_r;
        squash_n    = squash_r;
        accept      = 1'b0;
        capture     = 1'b0;
        int_ready_o = 1'b0;
        fp_ready_o  = 1'b0;
        unit_v_o    = 1'b0;
        unit_yumi_o = 1'b0;
        int_wb_v_o  = 1'b0;
        fp_wb_v_o   = 1'b0;

        unique case (state_r)
            IDLE: begin
                if (!flush_i) begin
                    int_ready_o = grant_int;
                    fp_ready_o  = grant_fp;
                    if (grant_int | grant_fp) begin
                        accept   = 1'b1;
                        tag_n.fp = grant_fp;
                        tag_n.op = grant_fp ? {1'b0, fp_sqrt_i} : int_op_i;
                        tag_n.rd = grant_fp ? fp_rd_i : int_rd_i;
                        squash_n = 1'b0;
                        state_n  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                unit_v_o = 1'b1;
                if (unit_ready_i) begin
                    // The unit has the op; a coincident flush can only mark it for dropping.
                    squash_n = flush_i;
                    state_n  = WAIT;
                end else if (flush_i) begin
                    state_n = IDLE;
                end
            end
            WAIT: begin
                unit_yumi_o = unit_v_i;
                if (flush_i) squash_n = 1'b1;
                if (unit_v_i) begin
                    if (squash_r | flush_i) begin
                        state_n = IDLE;
                    end else begin
                        capture = 1'b1;
                        state_n = WB;
                    end
                end
            end
            WB: begin
                // Flush is ignored here: the result is architecturally owed.
                int_wb_v_o = ~tag_r.fp;
                fp_wb_v_o  = tag_r.fp;
                if ((tag_r.fp & fp_wb_yumi_i) | (~tag_r.fp & int_wb_yumi_i))
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= IDLE;
            tag_r     <= '0;
            data_r    <= '0;
            squash_r  <= 1'b0;
            last_fp_r <= 1'b1;
        end else begin
            state_r  <= state_n;
            tag_r    <= tag_n;
            squash_r <= squash_n;
            if (accept)  last_fp_r <= grant_fp;
            if (capture) data_r    <= unit_data_i;
        end
    end

    assign unit_fp_o = (state_r == ISSUE) & tag_r.fp;
    assign unit_op_o = (state_r == ISSUE) ? tag_r.op : 2'b00;
    assign wb_rd_o   = (state_r == WB) ? tag_r.rd : '0;
    assign wb_data_o = (state_r == WB) ? data_r : '0;

    // Integer x0 is never written, so it cannot be a true dependency.
    logic pending, rd_match, x0_dest;
    assign pending  = (state_r != IDLE) & ~squash_r;
    assign rd_match = (id_rs1_i == tag_r.rd) | (id_rs2_i == tag_r.rd) | (id_rd_i == tag_r.rd);
    assign x0_dest  = ~tag_r.fp & (tag_r.rd == '0);
    assign hazard_o = pending & (id_fp_i == tag_r.fp) & rd_match & ~x0_dest;

    a_unit_v_only_in_wait: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) unit_v_i |-> (state_r == WAIT)
    );

endmodule

// File: tb/tb_vanilla_long_op_sequencer.sv
// Randomized self-checking bench: the bench plays both pipes, the divide unit
// and the writeback consumer, and predicts every transaction at transaction level.
module tb_vanilla_long_op_sequencer;
    import bsg_vanilla_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        int_v, int_ready, fp_v, fp_sqrt, fp_ready, flush;
    idiv_op_e    int_op;
    logic [4:0]  int_rd, fp_rd, wb_rd, id_rs1, id_rs2, id_rd;
    logic        unit_v, unit_fp, unit_ready, unit_res_v, unit_yumi;
    logic [1:0]  unit_op;
    logic [31:0] unit_data, wb_data;
    logic        int_wb_v, fp_wb_v, int_wb_yumi, fp_wb_yumi, id_fp, hazard;

    vanilla_long_op_sequencer #(.data_width_p(32), .reg_addr_width_p(5)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .int_v_i(int_v), .int_op_i(int_op), .int_rd_i(int_rd), .int_ready_o(int_ready),
        .fp_v_i(fp_v), .fp_sqrt_i(fp_sqrt), .fp_rd_i(fp_rd), .fp_ready_o(fp_ready),
        .flush_i(flush),
        .unit_v_o(unit_v), .unit_fp_o(unit_fp), .unit_op_o(unit_op), .unit_ready_i(unit_ready),
        .unit_v_i(unit_res_v), .unit_data_i(unit_data), .unit_yumi_o(unit_yumi),
        .int_wb_v_o(int_wb_v), .fp_wb_v_o(fp_wb_v), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .int_wb_yumi_i(int_wb_yumi), .fp_wb_yumi_i(fp_wb_yumi),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd), .id_fp_i(id_fp),
        .hazard_o(hazard)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who was granted last, and what the outstanding op is.
    logic       lg_fp;
    logic       m_busy, m_sq, m_fp;
    logic [4:0] m_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic hz_model();
        logic hit;
        hit = (id_rs1 == m_rd) || (id_rs2 == m_rd) || (id_rd == m_rd);
        return m_busy && !m_sq && (id_fp == m_fp) && hit && !(!m_fp && m_rd == 5'd0);
    endfunction

    // ID operands biased towards the outstanding destination; pipes poke at
    // the sequencer while busy to show nothing is accepted then.
    task automatic rand_id();
        id_fp  = ($urandom_range(0, 3) != 0) ? m_fp : ~m_fp;
        id_rs1 = ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom);
        id_rs2 = ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom);
        id_rd  = ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom);
        int_v  = m_busy ? 1'($urandom) : 1'b0;
        fp_v   = m_busy ? 1'($urandom) : 1'b0;
    endtask

    task automatic check_busy(input string ph);
        check({ph, "_int_ready"}, 64'(int_ready), 64'(0));
        check({ph, "_fp_ready"}, 64'(fp_ready), 64'(0));
        check({ph, "_hazard"}, 64'(hazard), 64'(hz_model()));
    endtask

    // mode: 0 int only, 1 fp only, 2 both. kind: 0 flush in ISSUE, 1 flush in WAIT,
    // 2 flush with the issue handshake, otherwise no flush.
    task automatic run_txn(input int mode, input logic [1:0] iop, input logic [4:0] ird,
                           input logic fsq, input logic [4:0] frd, input int kind,
                           input int stall, input int lat, input logic [31:0] data,
                           input int ydel);
        logic       win_fp, last;
        logic [1:0] eop;
        int         n_stall;
        n_stall = (kind == 0 && stall == 0) ? 1 : stall;

        m_busy = 1'b0;
        rand_id();
        int_v  = (mode != 1); int_op = idiv_op_e'(iop); int_rd = ird;
        fp_v   = (mode != 0); fp_sqrt = fsq; fp_rd = frd;
        win_fp = (mode == 2) ? !lg_fp : (mode == 1);
        #1;
        check("grant_int_ready", 64'(int_ready), 64'(!win_fp));
        check("grant_fp_ready", 64'(fp_ready), 64'(win_fp));
        check("idle_hazard", 64'(hazard), 64'(0));
        lg_fp  = win_fp;
        m_busy = 1'b1; m_sq = 1'b0; m_fp = win_fp;
        m_rd   = win_fp ? frd : ird;
        eop    = win_fp ? {1'b0, fsq} : iop;
        cyc();

        for (int i = 0; i < n_stall; i++) begin
            rand_id();
            unit_ready = 1'b0;
            flush = (kind == 0 && i == 0);
            #1;
            check("issue_unit_v", 64'(unit_v), 64'(1));
            check("issue_unit_fp", 64'(unit_fp), 64'(m_fp));
            check("issue_unit_op", 64'(unit_op), 64'(eop));
            check_busy("issue");
            cyc();
            flush = 1'b0;
            if (kind == 0) begin
                m_busy = 1'b0;
                rand_id();
                #1;
                check("flushed_unit_v", 64'(unit_v), 64'(0));
                check("flushed_wb_v", 64'({int_wb_v, fp_wb_v}), 64'(0));
                check("flushed_hazard", 64'(hazard), 64'(0));
                return;
            end
        end

        rand_id();
        unit_ready = 1'b1;
        flush = (kind == 2);
        #1;
        check("hs_unit_v", 64'(unit_v), 64'(1));
        check("hs_unit_fp", 64'(unit_fp), 64'(m_fp));
        check("hs_unit_op", 64'(unit_op), 64'(eop));
        check_busy("hs");
        cyc();
        unit_ready = 1'b0; flush = 1'b0;
        if (kind == 2) m_sq = 1'b1;

        for (int i = 0; i <= lat; i++) begin
            last = (i == lat);
            rand_id();
            unit_res_v = last;
            unit_data  = last ? data : $urandom;
            flush = (kind == 1 && i == 0);
            #1;
            check("wait_unit_yumi", 64'(unit_yumi), 64'(last));
            check("wait_unit_v", 64'(unit_v), 64'(0));
            check("wait_wb_v", 64'({int_wb_v, fp_wb_v}), 64'(0));
            check_busy("wait");
            if (flush) m_sq = 1'b1;
            cyc();
            unit_res_v = 1'b0; flush = 1'b0;
        end

        if (m_sq) begin
            m_busy = 1'b0;
            rand_id();
            #1;
            check("drop_wb_v", 64'({int_wb_v, fp_wb_v}), 64'(0));
            check("drop_hazard", 64'(hazard), 64'(0));
            return;
        end

        for (int i = 0; i <= ydel; i++) begin
            last = (i == ydel);
            rand_id();
            int_wb_yumi = last ? !m_fp : (m_fp & 1'($urandom));
            fp_wb_yumi  = last ? m_fp : (!m_fp & 1'($urandom));
            flush = 1'($urandom);
            #1;
            check("wb_int_v", 64'(int_wb_v), 64'(!m_fp));
            check("wb_fp_v", 64'(fp_wb_v), 64'(m_fp));
            check("wb_rd", 64'(wb_rd), 64'(m_rd));
            check("wb_data", 64'(wb_data), 64'(data));
            check_busy("wb");
            cyc();
            int_wb_yumi = 1'b0; fp_wb_yumi = 1'b0; flush = 1'b0;
        end

        m_busy = 1'b0;
        rand_id();
        #1;
        check("post_wb_v", 64'({int_wb_v, fp_wb_v}), 64'(0));
        check("post_hazard", 64'(hazard), 64'(0));
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({int_ready, fp_ready, unit_v, unit_fp, unit_op, unit_yumi,
                    int_wb_v, fp_wb_v, wb_rd, wb_data, hazard});
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        int_v = 1'b0; int_op = eDIV; int_rd = '0; fp_v = 1'b0; fp_sqrt = 1'b0; fp_rd = '0;
        flush = 1'b0; unit_ready = 1'b0; unit_res_v = 1'b0; unit_data = '0;
        int_wb_yumi = 1'b0; fp_wb_yumi = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_fp = 1'b0;
        lg_fp = 1'b1; m_busy = 1'b0; m_sq = 1'b0; m_fp = 1'b0; m_rd = '0;
        cyc(); cyc();
        check("reset_outputs", all_outputs(), 64'(0));
        reset_n = 1'b1;
        cyc();
    endtask

    initial begin
        do_reset();

        // Tie from reset goes to int, then alternates.
        for (int i = 0; i < 3; i++)
            run_txn(2, 2'($urandom), 5'(i + 1), 1'($urandom), 5'(i + 10), 3, 0, 1, $urandom, 0);

        do_reset();

        // FDIV rd=3 waiting in the unit: hazard only against the fp file.
        fp_v = 1'b1; fp_sqrt = 1'b0; fp_rd = 5'd3;
        #1;
        check("fdiv_fp_ready", 64'(fp_ready), 64'(1));
        cyc();
        fp_v = 1'b0; unit_ready = 1'b1;
        #1;
        check("fdiv_unit_fp", 64'(unit_fp), 64'(1));
        check("fdiv_unit_op", 64'(unit_op), 64'(0));
        cyc();
        unit_ready = 1'b0;
        id_fp = 1'b1; id_rs1 = 5'd7; id_rs2 = 5'd3; id_rd = 5'd9;
        #1;
        check("hz_fp_rs2", 64'(hazard), 64'(1));
        id_fp = 1'b0;
        #1;
        check("hz_int_file", 64'(hazard), 64'(0));
        unit_res_v = 1'b1; unit_data = 32'h0000_1234;
        cyc();
        unit_res_v = 1'b0;
        #1;
        check("fdiv_fp_wb_v", 64'(fp_wb_v), 64'(1));
        check("fdiv_int_wb_v", 64'(int_wb_v), 64'(0));
        check("fdiv_wb_rd", 64'(wb_rd), 64'(3));
        check("fdiv_wb_data", 64'(wb_data), 64'(32'h1234));
        fp_wb_yumi = 1'b1;
        cyc();
        fp_wb_yumi = 1'b0;
        lg_fp = 1'b1;

        // DIV rd=5, result 7 after 10 cycles, writeback held for 4 cycles.
        run_txn(0, eDIV, 5'd5, 1'b0, 5'd0, 3, 0, 10, 32'd7, 4);
        // Integer destination x0 never hazards.
        run_txn(0, eDIVU, 5'd0, 1'b0, 5'd0, 3, 1, 3, 32'hdead_beef, 1);
        // Flush in ISSUE without handshake, flush in WAIT, flush at handshake.
        run_txn(0, eREM, 5'd12, 1'b0, 5'd0, 0, 1, 0, 32'd1, 0);
        run_txn(1, eDIV, 5'd0, 1'b1, 5'd14, 1, 0, 4, 32'd2, 0);
        run_txn(2, eREMU, 5'd8, 1'b0, 5'd8, 2, 2, 2, 32'd3, 0);

        // Reset while the op is in WAIT: everything returns to zero at once.
        int_v = 1'b1; int_op = eDIV; int_rd = 5'd9; id_fp = 1'b0; id_rs1 = 5'd9;
        cyc();
        int_v = 1'b0; unit_ready = 1'b1;
        cyc();
        unit_ready = 1'b0;
        #1;
        check("wait_hazard_pre_reset", 64'(hazard), 64'(1));
        reset_n = 1'b0;
        #1;
        check("mid_wait_reset_outputs", all_outputs(), 64'(0));
        cyc();
        reset_n = 1'b1; lg_fp = 1'b1; m_busy = 1'b0;
        cyc();

        for (int t = 0; t < 300; t++)
            run_txn($urandom_range(0, 2), 2'($urandom), 5'($urandom), 1'($urandom),
                    5'($urandom), $urandom_range(0, 7), $urandom_range(0, 2),
                    $urandom_range(0, 5), $urandom, $urandom_range(0, 3));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
